// File: rtl/core_pkg.sv
// Shared core definitions: decoder op field, LSU state encoding, bus widths
// and helpers for access size, alignment, byte enables and lane replication.
package core;

  localparam int XLEN   = 32;
  localparam int STRB_W = XLEN / 8;
  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [3:0] {
    OP_NONE,
    OP_ALU,
    LOAD_BYTE,
    LOAD_HALF,
    LOAD_WORD,
    LOAD_BYTE_UNSIGNED,
    LOAD_HALF_UNSIGNED,
    STORE_BYTE,
    STORE_HALF,
    STORE_WORD
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } lsu_state_t;

  function automatic logic is_load(input op_t op);
    return op inside {LOAD_BYTE, LOAD_HALF, LOAD_WORD, LOAD_BYTE_UNSIGNED, LOAD_HALF_UNSIGNED};
  endfunction

  function automatic logic is_store(input op_t op);
    return op inside {STORE_BYTE, STORE_HALF, STORE_WORD};
  endfunction

  function automatic logic is_half(input op_t op);
    return op inside {LOAD_HALF, LOAD_HALF_UNSIGNED, STORE_HALF};
  endfunction

  function automatic logic is_word(input op_t op);
    return op inside {LOAD_WORD, STORE_WORD};
  endfunction

  function automatic logic is_aligned(input op_t op, input logic [1:0] off);
    if (is_word(op)) return off == 2'b00;
    if (is_half(op)) return !off[0];
    return 1'b1;
  endfunction

  function automatic logic [STRB_W-1:0] strb_of(input op_t op, input logic [1:0] off);
    if (is_word(op)) return '1;
    if (is_half(op)) return 4'b0011 << {off[1], 1'b0};
    return 4'b0001 << off;
  endfunction

  // Sub-word stores are replicated across every lane so the strobes alone pick the bytes.
  function automatic logic [XLEN-1:0] wdata_of(input op_t op, input logic [XLEN-1:0] wdata);
    if (is_word(op)) return wdata;
    if (is_half(op)) return {2{wdata[HALF_W-1:0]}};
    return {4{wdata[BYTE_W-1:0]}};
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a bus word and sign- or zero-extends it
// according to the load op.
module load_align
  import core::*;
(
  input  op_t             op,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    shifted = word >> {offset, 3'b000};
    result  = shifted;
    case (op)
      LOAD_BYTE:          result = {{(XLEN-BYTE_W){shifted[BYTE_W-1]}}, shifted[BYTE_W-1:0]};
      LOAD_BYTE_UNSIGNED: result = {{(XLEN-BYTE_W){1'b0}}, shifted[BYTE_W-1:0]};
      LOAD_HALF:          result = {{(XLEN-HALF_W){shifted[HALF_W-1]}}, shifted[HALF_W-1:0]};
      LOAD_HALF_UNSIGNED: result = {{(XLEN-HALF_W){1'b0}}, shifted[HALF_W-1:0]};
      default:            result = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding bus transaction at a time, with alignment
// checks, flush handling and a response timeout.
module lsu
  import core::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  input  op_t               op,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [XLEN-1:0]   rdata,
  output logic              misaligned,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [STRB_W-1:0] mem_strb,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  lsu_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  op_t               op_q;
  logic [XLEN-1:2]   addr_q;
  logic [1:0]        off_q;
  logic              we_q;
  logic [STRB_W-1:0] strb_q;
  logic [XLEN-1:0]   wdata_q, rdata_q, load_res;
  logic              done_q, done_d, fault_q, fault_d, misal_q;
  logic              mem_op, start, accept, misal_d, timeout;

  // The instruction still on the inputs in a done/fault cycle is the one just retired.
  assign mem_op  = valid & (is_load(op) | is_store(op));
  assign start   = (state_q == IDLE) & mem_op & ~flush & ~done_q & ~fault_q;
  assign accept  = start & is_aligned(op, addr[1:0]);
  assign misal_d = start & ~is_aligned(op, addr[1:0]);
  assign timeout = (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fault_d = 1'b0;
    case (state_q)
      IDLE:  if (accept) state_d = REQ;
      REQ: begin
        if (flush)        state_d = IDLE;
        else if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (flush) begin
          state_d = mem_rvalid ? IDLE : DRAIN;
        end else if (mem_rvalid) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (timeout) begin
          state_d = IDLE;
          fault_d = 1'b1;
        end
      end
      DRAIN: if (mem_rvalid || timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q)                       cnt_d = '0;
    else if (state_q == WAIT || state_q == DRAIN) cnt_d = cnt_q + CNT_W'(1);
  end

  load_align u_load_align (
    .op     (op_q),
    .offset (off_q),
    .word   (mem_rdata),
    .result (load_res)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= OP_NONE;
      addr_q  <= '0;
      off_q   <= '0;
      we_q    <= 1'b0;
      strb_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      misal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      misal_q <= misal_d;
      if (accept) begin
        op_q    <= op;
        addr_q  <= addr[XLEN-1:2];
        off_q   <= addr[1:0];
        we_q    <= is_store(op);
        strb_q  <= is_store(op) ? strb_of(op, addr[1:0]) : '0;
        wdata_q <= is_store(op) ? wdata_of(op, wdata) : '0;
      end
      if (done_d && !we_q) rdata_q <= load_res;
    end
  end

  assign stall      = resetn & ((state_q != IDLE) | accept);
  assign done       = done_q;
  assign rdata      = rdata_q;
  assign misaligned = misal_q;
  assign fault      = fault_q;
  assign mem_req    = (state_q == REQ);
  assign mem_we     = (state_q == REQ) & we_q;
  assign mem_addr   = {addr_q, 2'b00};
  assign mem_strb   = strb_q;
  assign mem_wdata  = wdata_q;

endmodule
